// File: rtl/ext_bus_bridge_if.sv
// Bus bundle between the chip core, the bridge and the two memory targets.
// The bridge takes the slave view; the core side/testbench takes the master view.
interface ext_bus_bridge_if #(
    parameter int ABITS      = 16,
    parameter int DBITS      = 8,
    parameter int SRAM_ABITS = 14
);
    logic [ABITS-1:0]      bus_a;
    logic [DBITS-1:0]      bus_dout;
    logic                  bus_wr;
    logic                  bus_cs;
    logic                  bus_cale;
    logic [DBITS-1:0]      bus_din;
    logic                  bus_ready;
    logic                  overrun;
    logic [ABITS-1:0]      cart_a;
    logic [DBITS-1:0]      cart_dout;
    logic [DBITS-1:0]      cart_din;
    logic                  cart_wr;
    logic                  cart_rd;
    logic [SRAM_ABITS-1:0] sram_a;
    logic [DBITS-1:0]      sram_wdata;
    logic [DBITS-1:0]      sram_rdata;
    logic                  sram_we;

    modport slave (
        input  bus_a, bus_dout, bus_wr, bus_cs, bus_cale, cart_din, sram_rdata,
        output bus_din, bus_ready, overrun, cart_a, cart_dout, cart_wr, cart_rd,
               sram_a, sram_wdata, sram_we
    );

    modport master (
        output bus_a, bus_dout, bus_wr, bus_cs, bus_cale, cart_din, sram_rdata,
        input  bus_din, bus_ready, overrun, cart_a, cart_dout, cart_wr, cart_rd,
               sram_a, sram_wdata, sram_we
    );
endinterface

// File: rtl/ext_bus_bridge.sv
// Registered transaction engine bridging the multiplexed core bus to work SRAM
// and the cartridge port, with per-target wait states and overrun detection.
module ext_bus_bridge #(
    parameter int ABITS      = 16,
    parameter int DBITS      = 8,
    parameter int SRAM_ABITS = 14,
    parameter int CART_WAIT  = 2,
    parameter int SRAM_WAIT  = 0
) (
    input logic              clk,
    input logic              rst,
    ext_bus_bridge_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [ABITS-1:0]  addr_q;
    logic [DBITS-1:0]  data_q;
    logic [DBITS-1:0]  din_q;
    logic              wr_q;
    logic              cs_q;
    logic              overrun_q;
    logic              accept;
    logic              last_access;

    assign last_access = (state_q == ACCESS) && (wait_q == 4'd0);

    // Next-state logic; a strobe is accepted in IDLE and, for back-to-back use, in DONE.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.bus_cale) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            DONE: begin
                if (bus.bus_cale) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            wait_d = bus.bus_cs ? 4'(CART_WAIT) : 4'(SRAM_WAIT);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= 4'd0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            cs_q      <= 1'b0;
            din_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) begin
                addr_q <= bus.bus_a;
                data_q <= bus.bus_dout;
                wr_q   <= bus.bus_wr;
                cs_q   <= bus.bus_cs;
            end
            // Read data is taken on the last access edge so it lines up with bus_ready.
            if (last_access && !wr_q) begin
                din_q <= cs_q ? bus.cart_din : bus.sram_rdata;
            end
            if ((state_q == ACCESS) && bus.bus_cale) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.bus_din    = din_q;
    assign bus.bus_ready  = (state_q == DONE);
    assign bus.overrun    = overrun_q;
    assign bus.cart_a     = addr_q;
    assign bus.cart_dout  = data_q;
    assign bus.cart_wr    = (state_q == ACCESS) && cs_q && wr_q;
    assign bus.cart_rd    = (state_q == ACCESS) && cs_q && !wr_q;
    assign bus.sram_a     = addr_q[SRAM_ABITS-1:0];
    assign bus.sram_wdata = data_q;
    // SRAM writes are a single strobe in the closing access cycle, after the address has settled.
    assign bus.sram_we    = last_access && !cs_q && wr_q;

endmodule
